// File: rtl/spike_pkg.sv
// Shared types and constants for the spike event scheduler.
package spike_pkg;
    localparam int SAMPLE_W        = 16;
    localparam int DEFAULT_LOCKOUT = 20;

    typedef logic signed [SAMPLE_W-1:0] sample_t;

    // Samples at or below this level are amplifier saturation, not neural activity.
    localparam sample_t SATURATION_NEG = -16'sd30000;
    localparam sample_t THR_DISABLED   = 16'sh8000;

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } scan_state_t;
endpackage

// File: rtl/spike_event_fifo.sv
// Single-clock event queue; a push on a full queue succeeds only alongside a pop.
module spike_event_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic [W-1:0] pop_data,
    output logic         full,
    output logic         empty
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [W-1:0]     mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full     = (count == CNT_W'(DEPTH));
    assign empty    = (count == '0);
    assign do_pop   = pop && !empty;
    assign do_push  = push && (!full || do_pop);
    assign pop_data = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= ptr_next(wr_ptr);
            if (do_pop)  rd_ptr <= ptr_next(rd_ptr);
            count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end
endmodule

// File: rtl/spike_event_scheduler.sv
// Time-multiplexed threshold spike detector: scans one channel per cycle,
// applies a per-channel refractory lockout and queues detected events.
module spike_event_scheduler
    import spike_pkg::*;
#(
    parameter int NCH        = 8,
    parameter int LOCKOUT    = DEFAULT_LOCKOUT,
    parameter int FIFO_DEPTH = 4,
    localparam int CH_W      = $clog2(NCH)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      frame_valid,
    output logic                      frame_ready,
    input  logic [NCH*SAMPLE_W-1:0]   frame_data,
    input  logic                      cfg_we,
    input  logic [CH_W-1:0]           cfg_ch,
    input  logic signed [SAMPLE_W-1:0] cfg_thr,
    output logic                      ev_valid,
    input  logic                      ev_ready,
    output logic [CH_W-1:0]           ev_ch,
    output logic                      ev_overflow,
    output logic                      busy
);
    localparam int TMR_W = $clog2(LOCKOUT + 1);

    scan_state_t      state;
    logic [CH_W-1:0]  scan_idx;
    sample_t          frame_p0 [NCH];
    sample_t          thr      [NCH];
    logic [TMR_W-1:0] timer    [NCH];

    sample_t cur_sample;
    logic    timer_active;
    logic    detect;
    logic    ev_pop;
    logic    fifo_full;
    logic    fifo_empty;

    function automatic logic is_spike(input sample_t s, input sample_t t);
        return (s < t) && (s > SATURATION_NEG);
    endfunction

    assign cur_sample   = frame_p0[scan_idx];
    assign timer_active = (timer[scan_idx] != '0);
    assign detect       = (state == SCAN) && !timer_active && is_spike(cur_sample, thr[scan_idx]);
    assign ev_valid     = !fifo_empty;
    assign ev_pop       = ev_valid && ev_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            frame_ready <= 1'b1;
            busy        <= 1'b0;
            scan_idx    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (frame_valid) begin
                        state       <= SCAN;
                        frame_ready <= 1'b0;
                        busy        <= 1'b1;
                        scan_idx    <= '0;
                    end
                end
                SCAN: begin
                    if (scan_idx == CH_W'(NCH - 1)) begin
                        state       <= IDLE;
                        frame_ready <= 1'b1;
                        busy        <= 1'b0;
                        scan_idx    <= '0;
                    end else begin
                        scan_idx <= scan_idx + 1'b1;
                    end
                end
                default: begin
                    state       <= IDLE;
                    frame_ready <= 1'b1;
                    busy        <= 1'b0;
                    scan_idx    <= '0;
                end
            endcase
        end
    end

    // Frame capture stage: samples held for the whole scan.
    always_ff @(posedge clk) begin
        if (state == IDLE && frame_valid) begin
            for (int i = 0; i < NCH; i++) begin
                frame_p0[i] <= frame_data[i*SAMPLE_W +: SAMPLE_W];
            end
        end
    end

    // Evaluation stage: thresholds and refractory timers.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NCH; i++) begin
                thr[i]   <= THR_DISABLED;
                timer[i] <= '0;
            end
        end else begin
            if (cfg_we) thr[cfg_ch] <= cfg_thr;
            if (state == SCAN) begin
                if (timer_active) begin
                    timer[scan_idx] <= timer[scan_idx] - 1'b1;
                end else if (detect) begin
                    timer[scan_idx] <= TMR_W'(LOCKOUT);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ev_overflow <= 1'b0;
        end else if (detect && fifo_full && !ev_pop) begin
            ev_overflow <= 1'b1;
        end
    end

    spike_event_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (CH_W)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (detect),
        .push_data (scan_idx),
        .pop       (ev_pop),
        .pop_data  (ev_ch),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );
endmodule

// File: tb/tb_spike_event_scheduler.sv
// Scoreboard bench for spike_event_scheduler with a queue-based reference model.
module tb_spike_event_scheduler;
    localparam int NCH   = 8;
    localparam int LOCK  = 20;
    localparam int DEPTH = 4;
    localparam int CH_W  = 3;

    logic                    clk = 1'b0;
    logic                    rst = 1'b1;
    logic                    frame_valid = 1'b0;
    logic                    frame_ready;
    logic [NCH*16-1:0]       frame_data = '0;
    logic                    cfg_we = 1'b0;
    logic [CH_W-1:0]         cfg_ch = '0;
    logic signed [15:0]      cfg_thr = '0;
    logic                    ev_valid;
    logic                    ev_ready = 1'b1;
    logic [CH_W-1:0]         ev_ch;
    logic                    ev_overflow;
    logic                    busy;

    always #5 clk = ~clk;

    spike_event_scheduler #(
        .NCH        (NCH),
        .LOCKOUT    (LOCK),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .frame_valid (frame_valid),
        .frame_ready (frame_ready),
        .frame_data  (frame_data),
        .cfg_we      (cfg_we),
        .cfg_ch      (cfg_ch),
        .cfg_thr     (cfg_thr),
        .ev_valid    (ev_valid),
        .ev_ready    (ev_ready),
        .ev_ch       (ev_ch),
        .ev_overflow (ev_overflow),
        .busy        (busy)
    );

    // Reference model: per-channel thresholds/timers as integers, event queue as a queue.
    int  m_thr   [NCH];
    int  m_timer [NCH];
    int  m_frame [NCH];
    bit  m_busy;
    int  m_idx;
    bit  m_ovf;
    bit  m_init = 1'b0;
    bit  m_after_rst;
    int  exp_q [$];

    always @(posedge clk) begin : model
        bit pop;
        bit push;
        int c;
        m_init = 1'b1;
        if (rst) begin
            for (int i = 0; i < NCH; i++) begin
                m_thr[i]   = -32768;
                m_timer[i] = 0;
            end
            m_busy      = 1'b0;
            m_idx       = 0;
            m_ovf       = 1'b0;
            m_after_rst = 1'b1;
            exp_q.delete();
        end else begin
            pop  = (exp_q.size() > 0) && ev_ready;
            push = 1'b0;
            c    = 0;
            if (pop) void'(exp_q.pop_front());
            if (m_busy) begin
                c = m_idx;
                if (m_timer[c] > 0) begin
                    m_timer[c] = m_timer[c] - 1;
                end else if (m_frame[c] < m_thr[c] && m_frame[c] > -30000) begin
                    push       = 1'b1;
                    m_timer[c] = LOCK;
                end
                m_idx = m_idx + 1;
                if (m_idx == NCH) m_busy = 1'b0;
            end else if (frame_valid) begin
                for (int i = 0; i < NCH; i++) m_frame[i] = int'($signed(frame_data[16*i +: 16]));
                m_busy = 1'b1;
                m_idx  = 0;
            end
            if (cfg_we) m_thr[cfg_ch] = int'(cfg_thr);
            if (push) begin
                m_after_rst = 1'b0;
                if (exp_q.size() >= DEPTH) m_ovf = 1'b1;
                else exp_q.push_back(c);
            end
        end
    end

    int n_cmp = 0;
    int n_bad = 0;
    int to_cnt = 0;
    bit final_req = 1'b0;
    bit final_done = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin : monitor
        if (m_init) begin
            chk("ev_valid", int'(ev_valid), int'(exp_q.size() > 0));
            chk("ev_overflow", int'(ev_overflow), int'(m_ovf));
            chk("frame_ready", int'(frame_ready), int'(!m_busy));
            chk("busy", int'(busy), int'(m_busy));
            if (ev_valid && exp_q.size() > 0) chk("ev_ch", int'(ev_ch), exp_q[0]);
            if (m_after_rst && exp_q.size() == 0) chk("ev_ch_after_reset", int'(ev_ch), 0);
        end
        if (final_req && !final_done) begin
            chk("queue_drained", exp_q.size(), 0);
            chk("bounded_waits", to_cnt, 0);
            final_done = 1'b1;
        end
    end

    bit rnd_rdy = 1'b0;

    task automatic tick();
        @(posedge clk);
        #1;
        if (rnd_rdy) ev_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic cfg_write(input int ch, input int thr);
        cfg_we  = 1'b1;
        cfg_ch  = CH_W'(ch);
        cfg_thr = 16'(thr);
        tick();
        cfg_we  = 1'b0;
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!frame_ready && n < 100) begin
            tick();
            n++;
        end
        if (!frame_ready) to_cnt++;
    endtask

    task automatic send_frame(input logic [NCH*16-1:0] d);
        wait_ready();
        frame_valid = 1'b1;
        frame_data  = d;
        tick();
        frame_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        ev_ready = 1'b1;
        while ((ev_valid || !frame_ready) && n < 200) begin
            tick();
            n++;
        end
        if (ev_valid || !frame_ready) to_cnt++;
        tick();
    endtask

    function automatic logic [NCH*16-1:0] fr_all(input int v);
        logic [NCH*16-1:0] f;
        for (int i = 0; i < NCH; i++) f[16*i +: 16] = 16'(v);
        return f;
    endfunction

    function automatic logic [NCH*16-1:0] fr_set(input logic [NCH*16-1:0] f, input int ch, input int v);
        logic [NCH*16-1:0] r;
        r = f;
        r[16*ch +: 16] = 16'(v);
        return r;
    endfunction

    function automatic int pick_sample();
        case ($urandom_range(0, 8))
            0: return -500;
            1: return -30000;
            2: return -29999;
            3: return -30001;
            4: return -32768;
            5: return 0;
            6: return -100;
            7: return -101;
            default: return int'($urandom_range(0, 65535)) - 32768;
        endcase
    endfunction

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        logic [NCH*16-1:0] f;
        repeat (3) tick();
        rst = 1'b0;
        tick();

        // Single event on channel 3.
        cfg_write(3, -100);
        send_frame(fr_set(fr_all(0), 3, -500));
        drain();

        // Refractory lockout across 25 frames on channel 0.
        cfg_write(0, -100);
        for (int k = 0; k < 25; k++) send_frame(fr_set(fr_all(0), 0, -500));
        drain();

        // Saturated sample ignored, then a real spike detected.
        cfg_write(1, -100);
        send_frame(fr_set(fr_all(0), 1, -31000));
        send_frame(fr_set(fr_all(0), 1, -500));
        drain();

        // Queue overflow with consumer stalled, then ordered drain.
        do_reset();
        for (int c = 0; c < NCH; c++) cfg_write(c, -100);
        ev_ready = 1'b0;
        send_frame(fr_all(-500));
        wait_ready();
        repeat (3) tick();
        drain();

        // Threshold write landing on the cycle channel 2 is evaluated.
        do_reset();
        send_frame(fr_set(fr_all(0), 2, -500));
        tick();
        tick();
        cfg_write(2, -100);
        send_frame(fr_set(fr_all(0), 2, -500));
        drain();

        // Reset in the middle of a scan with events pending.
        do_reset();
        for (int c = 0; c < NCH; c++) cfg_write(c, -100);
        ev_ready = 1'b0;
        send_frame(fr_all(-500));
        repeat (3) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        ev_ready = 1'b1;
        cfg_write(0, -100);
        send_frame(fr_set(fr_all(0), 0, -500));
        drain();

        // Randomized frames, thresholds, mid-scan writes and consumer back-pressure.
        do_reset();
        for (int c = 0; c < NCH; c++) cfg_write(c, ($urandom_range(0, 1) == 1) ? -100 : pick_sample());
        rnd_rdy = 1'b1;
        for (int k = 0; k < 60; k++) begin
            for (int c = 0; c < NCH; c++) f[16*c +: 16] = 16'(pick_sample());
            send_frame(f);
            for (int j = 0; j < int'($urandom_range(0, 4)); j++) begin
                if ($urandom_range(0, 2) == 0) cfg_write(int'($urandom_range(0, NCH - 1)), pick_sample());
                else tick();
            end
        end
        rnd_rdy = 1'b0;
        drain();

        final_req = 1'b1;
        repeat (3) tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
